multicycle_ctrl_ws: RTL and testbench

//  Moore multicycle controller for the ARM-style datapath with wait-state memory: every memory access holds until mem_ready.

---
 rtl/multicycle_ctrl_ws.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl_ws.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_ws.sv
// multicycle_ctrl_ws: Moore multicycle controller with wait-state memory, bus timeout and sticky fault
// Ports:
//   clk, rst (sync, active-low)          clock and reset
//   access, opc, ir                      condition result, opcode, instruction register
//   mem_ready                            memory completes the pending access this cycle
//   pc_write .. c_write, mem_to_reg,
//   alu_src_b                            datapath and flag strobes, all decoded from state
//   fault, fault_code                    sticky fault indication (1 undefined, 2 bus timeout)
module multicycle_ctrl_ws #(
    parameter int OPC_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access,
    input  logic [OPC_W-1:0] opc,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_write,
    output logic             mem_read,
    output logic             ir_write,
    output logic             reg_in,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             alu_func,
    output logic             z_write,
    output logic             n_write,
    output logic             v_write,
    output logic             c_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_b,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam logic [3:0] START      = 4'd0;
    localparam logic [3:0] FETCH      = 4'd1;
    localparam logic [3:0] FETCH_DONE = 4'd2;
    localparam logic [3:0] DECODE     = 4'd3;
    localparam logic [3:0] ARITH      = 4'd4;
    localparam logic [3:0] LOGIC      = 4'd5;
    localparam logic [3:0] CMP        = 4'd6;
    localparam logic [3:0] LOAD       = 4'd7;
    localparam logic [3:0] LOAD_WB    = 4'd8;
    localparam logic [3:0] STORE      = 4'd9;
    localparam logic [3:0] BRANCH     = 4'd10;
    localparam logic [3:0] FAULT      = 4'd11;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    logic [3:0]    state, state_nxt, dp_nxt, cls_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    code;
    logic [31:0]   opc_v;
    logic          waiting, bus_fault, dec_undef;
    logic          unused_ir;

    assign unused_ir = ^{ir[31:30], ir[27], ir[25:24], ir[22:21], ir[19:0]};
    assign opc_v     = 32'(opc);
    assign waiting   = state == FETCH || state == LOAD || state == STORE;
    // ready in the last allowed cycle still completes the access
    assign bus_fault = waiting && !mem_ready && cnt == T_LAST;
    assign dp_nxt    = opc_v <= 2 ? ARITH : (opc_v == 5 || opc_v == 6) ? CMP : opc_v <= 7 ? LOGIC : FAULT;
    assign cls_nxt   = ir[29:28] == 2'b00 ? dp_nxt : ir[29:28] == 2'b01 ? (ir[20] ? STORE : LOAD) :
                       ir[29:28] == 2'b10 ? BRANCH : FAULT;
    assign dec_undef = access && cls_nxt == FAULT;
    assign fault      = state == FAULT;
    assign fault_code = code;

    always_comb begin
        state_nxt = START;
        case (state)
            START:                             state_nxt = FETCH;
            FETCH:                             state_nxt = mem_ready ? FETCH_DONE : bus_fault ? FAULT : FETCH;
            FETCH_DONE:                        state_nxt = DECODE;
            DECODE:                            state_nxt = access ? cls_nxt : FETCH;
            ARITH, LOGIC, CMP, BRANCH, LOAD_WB: state_nxt = FETCH;
            LOAD:                              state_nxt = mem_ready ? LOAD_WB : bus_fault ? FAULT : LOAD;
            STORE:                             state_nxt = mem_ready ? FETCH : bus_fault ? FAULT : STORE;
            FAULT:                             state_nxt = FAULT;
            default:                           state_nxt = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= START;
            cnt   <= '0;
            code  <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (waiting && !mem_ready) ? cnt + 1'b1 : '0;
            code  <= (state == DECODE && dec_undef) ? 2'd1 : bus_fault ? 2'd2 : code;
        end
    end

    always_comb begin
        {pc_write, iord, mem_write, mem_read, ir_write, reg_in, reg_dst, reg_write} = '0;
        {alu_src_a, alu_func, z_write, n_write, v_write, c_write} = '0;
        mem_to_reg = 2'd0;
        alu_src_b  = 2'd0;
        case (state)
            FETCH: mem_read = 1'b1;
            FETCH_DONE: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'd2;
            end
            ARITH, LOGIC, CMP: begin
                alu_src_a = 1'b1;
                alu_src_b = {1'b0, ir[23]};
                alu_func  = 1'b1;
                reg_dst   = state == LOGIC;
                reg_write = state != CMP;
                z_write   = 1'b1;
                n_write   = state == CMP ? ~opc[0] : 1'b1;
                v_write   = state == ARITH || (state == CMP && !opc[0]);
                c_write   = state != LOGIC;
            end
            LOAD, LOAD_WB, STORE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd1;
                iord       = 1'b1;
                mem_read   = state == LOAD;
                mem_write  = state == STORE;
                reg_in     = state == STORE;
                mem_to_reg = state == LOAD_WB ? 2'd1 : 2'd0;
                reg_write  = state == LOAD_WB;
            end
            BRANCH: begin
                alu_src_b  = 2'd3;
                pc_write   = 1'b1;
                mem_to_reg = 2'd2;
                reg_dst    = 1'b1;
                reg_write  = ir[26];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl_ws.sv
// tb_multicycle_ctrl_ws: transaction-level model of multicycle_ctrl_ws driven by directed and random instructions
module tb_multicycle_ctrl_ws;
  localparam int T = 4;
  typedef struct packed {
    logic       pc_write, iord, mem_write, mem_read, ir_write, reg_in, reg_dst, reg_write;
    logic       alu_src_a, alu_func, z_write, n_write, v_write, c_write;
    logic [1:0] mem_to_reg, alu_src_b;
    logic       fault;
    logic [1:0] fault_code;
  } outs_t;
  typedef enum {K_SKIP, K_ARITH, K_LOGIC, K_CMP, K_LOAD, K_STORE, K_BRANCH, K_UNDEF,
                K_FETCH, K_FDONE, K_LOADWB} kind_t;
  typedef struct {
    logic        rst, acc, rdy;
    logic [31:0] ir;
    logic [2:0]  opc;
    outs_t       exp;
    logic [63:0] tag;
  } cyc_t;
  typedef struct {
    logic       acc;
    logic [1:0] cls;
    logic [2:0] opc;
    logic       imm, lnk, ls;
    int         fw, mw;
    kind_t      k;
  } vec_t;
  logic        clk = 0, rst = 0, access = 0, mem_ready = 0;
  logic [2:0]  opc = '0;
  logic [31:0] ir = '0;
  logic        pc_write, iord, mem_write, mem_read, ir_write, reg_in, reg_dst, reg_write;
  logic        alu_src_a, alu_func, z_write, n_write, v_write, c_write, fault;
  logic [1:0]  mem_to_reg, alu_src_b, fault_code;
  outs_t       act;
  cyc_t        q[$];
  vec_t        tbl[14];
  logic        cur_acc;
  logic [31:0] cur_ir;
  logic [2:0]  cur_opc;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_ctrl_ws #(.OPC_W(3), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .access(access), .opc(opc), .ir(ir), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_write(mem_write), .mem_read(mem_read),
    .ir_write(ir_write), .reg_in(reg_in), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_func(alu_func), .z_write(z_write), .n_write(n_write),
    .v_write(v_write), .c_write(c_write), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .fault(fault), .fault_code(fault_code)
  );
  assign act = {pc_write, iord, mem_write, mem_read, ir_write, reg_in, reg_dst, reg_write,
                alu_src_a, alu_func, z_write, n_write, v_write, c_write,
                mem_to_reg, alu_src_b, fault, fault_code};
  function automatic kind_t classify(logic acc, logic [31:0] irv, logic [2:0] op);
    if (!acc) return K_SKIP;
    case (irv[29:28])
      2'b00:   return op <= 2 ? K_ARITH : (op == 5 || op == 6) ? K_CMP : K_LOGIC;
      2'b01:   return irv[20] ? K_STORE : K_LOAD;
      2'b10:   return K_BRANCH;
      default: return K_UNDEF;
    endcase
  endfunction
  function automatic outs_t model(kind_t k, logic [31:0] irv, logic [2:0] op);
    outs_t e = '0;
    case (k)
      K_FETCH: e.mem_read = 1;
      K_FDONE: begin e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2; end
      K_ARITH: begin
        e.alu_src_a = 1; e.alu_src_b = {1'b0, irv[23]}; e.alu_func = 1; e.reg_write = 1;
        e.z_write = 1; e.n_write = 1; e.v_write = 1; e.c_write = 1;
      end
      K_LOGIC: begin
        e.alu_src_a = 1; e.alu_src_b = {1'b0, irv[23]}; e.alu_func = 1; e.reg_write = 1;
        e.reg_dst = 1; e.z_write = 1; e.n_write = 1;
      end
      K_CMP: begin
        e.alu_src_a = 1; e.alu_src_b = {1'b0, irv[23]}; e.alu_func = 1;
        e.z_write = 1; e.c_write = 1; e.n_write = ~op[0]; e.v_write = ~op[0];
      end
      K_LOAD:   begin e.alu_src_a = 1; e.alu_src_b = 1; e.iord = 1; e.mem_read = 1; end
      K_LOADWB: begin e.alu_src_a = 1; e.alu_src_b = 1; e.iord = 1; e.mem_to_reg = 1; e.reg_write = 1; end
      K_STORE:  begin e.alu_src_a = 1; e.alu_src_b = 1; e.iord = 1; e.mem_write = 1; e.reg_in = 1; end
      K_BRANCH: begin
        e.alu_src_b = 3; e.pc_write = 1; e.mem_to_reg = 2; e.reg_dst = 1; e.reg_write = irv[26];
      end
      default: ;
    endcase
    return e;
  endfunction
  task automatic push(input logic r, input outs_t e, input logic [63:0] t, input logic rd);
    cyc_t c;
    c.rst = r; c.acc = cur_acc; c.ir = cur_ir; c.opc = cur_opc; c.exp = e; c.tag = t; c.rdy = rd;
    q.push_back(c);
  endtask
  task automatic push_reset(input outs_t e);
    push(0, e, "RSTIN", 1'($urandom));
    push(0, '0, "RESET", 1'($urandom));
    push(1, '0, "START", 1'($urandom));
  endtask
  task automatic push_fault(input logic [1:0] code);
    outs_t e = '0;
    e.fault = 1; e.fault_code = code;
    repeat (3) push(1, e, "FAULT", 1'($urandom));
    push_reset(e);
  endtask
  task automatic mem_phase(input kind_t k, input logic [63:0] t, input int w, output bit f);
    int n = w >= T ? T : w + 1;
    for (int i = 0; i < n; i++) push(1, model(k, cur_ir, cur_opc), t, w < T && i == n - 1);
    f = w >= T;
    if (f) push_fault(2);
  endtask
  task automatic gen(input logic acc, input logic [31:0] irv, input logic [2:0] op,
                     input kind_t k, input int fw, input int mw);
    bit f;
    cur_acc = acc; cur_ir = irv; cur_opc = op;
    mem_phase(K_FETCH, "FETCH", fw, f);
    if (f) return;
    push(1, model(K_FDONE, irv, op), "FDONE", 1'($urandom));
    push(1, '0, "DECODE", 1'($urandom));
    case (k)
      K_SKIP:  ;
      K_UNDEF: push_fault(1);
      K_LOAD: begin
        mem_phase(K_LOAD, "LOAD", mw, f);
        if (!f) push(1, model(K_LOADWB, irv, op), "LOADWB", 1'($urandom));
      end
      K_STORE: mem_phase(K_STORE, "STORE", mw, f);
      default: push(1, model(k, irv, op), "EXEC", 1'($urandom));
    endcase
  endtask
  function automatic logic [31:0] mk_ir(logic [1:0] cls, logic imm, logic lnk, logic ls);
    logic [31:0] v = $urandom;
    v[29:28] = cls; v[26] = lnk; v[23] = imm; v[20] = ls;
    return v;
  endfunction
  initial begin
    tbl = '{
      '{1, 2'd0, 3'd1, 1, 0, 0, 3, 0, K_ARITH},
      '{1, 2'd1, 3'd0, 0, 0, 0, 0, 2, K_LOAD},
      '{1, 2'd2, 3'd0, 0, 1, 0, 0, 0, K_BRANCH},
      '{1, 2'd2, 3'd0, 0, 0, 0, 1, 0, K_BRANCH},
      '{1, 2'd1, 3'd0, 1, 0, 1, 0, 9, K_STORE},
      '{1, 2'd1, 3'd0, 0, 0, 1, 0, 3, K_STORE},
      '{1, 2'd3, 3'd0, 0, 0, 0, 0, 0, K_UNDEF},
      '{0, 2'd3, 3'd0, 0, 0, 0, 0, 0, K_SKIP},
      '{1, 2'd0, 3'd5, 0, 0, 0, 0, 0, K_CMP},
      '{1, 2'd0, 3'd6, 1, 0, 0, 0, 0, K_CMP},
      '{1, 2'd0, 3'd7, 0, 0, 0, 0, 0, K_LOGIC},
      '{1, 2'd0, 3'd3, 1, 0, 0, 0, 0, K_LOGIC},
      '{1, 2'd0, 3'd4, 0, 0, 0, 4, 0, K_LOGIC},
      '{1, 2'd0, 3'd0, 0, 0, 0, 0, 3, K_ARITH}
    };
    cur_acc = 0; cur_ir = '0; cur_opc = '0;
    push(1, '0, "RSTSTATE", 0);
    for (int i = 0; i < 14; i++)
      gen(tbl[i].acc, mk_ir(tbl[i].cls, tbl[i].imm, tbl[i].lnk, tbl[i].ls), tbl[i].opc,
          tbl[i].k, tbl[i].fw, tbl[i].mw);
    cur_acc = 1; cur_ir = mk_ir(2'd1, 0, 0, 0); cur_opc = 0;
    push(1, model(K_FETCH, cur_ir, 0), "FETCH", 1);
    push(1, model(K_FDONE, cur_ir, 0), "FDONE", 0);
    push(1, '0, "DECODE", 0);
    push(1, model(K_LOAD, cur_ir, 0), "LOAD", 0);
    push_reset(model(K_LOAD, cur_ir, 0));
    push(1, model(K_FETCH, cur_ir, 0), "FETCH", 0);
    push_reset(model(K_FETCH, cur_ir, 0));
    for (int i = 0; i < 200; i++) begin
      logic        a  = ($urandom % 8) != 0;
      logic [31:0] iv = $urandom;
      logic [2:0]  op = 3'($urandom);
      int fw = ($urandom % 4 == 0) ? $urandom_range(0, T + 1) : $urandom_range(0, 2);
      int mw = ($urandom % 4 == 0) ? $urandom_range(0, T + 1) : $urandom_range(0, 2);
      gen(a, iv, op, classify(a, iv, op), fw, mw);
    end
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act !== '0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got %h want 0", act);
    end
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst = q[i].rst; access = q[i].acc; ir = q[i].ir; opc = q[i].opc; mem_ready = q[i].rdy;
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL %s slot %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      if (q[i].tag == "FAULT") begin
        checks++;
        if (fault !== 1'b1 || fault_code !== q[i].exp.fault_code) begin
          errors++;
          $display("FAIL fault slot %0d: fault %b code %0d want code %0d", i, fault, fault_code, q[i].exp.fault_code);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
